// File: rtl/lcd_stream_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_stream_ctrl_pkg
// Description : Shared definitions for the LCD stream controller. Holds the
//               KS0108-style command bytes, the main FSM state encoding, the
//               bus-write phase encoding and a page-command helper.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_stream_ctrl_pkg;

    localparam logic [7:0] CMD_DISP_ON    = 8'h3F;
    localparam logic [7:0] CMD_START_LINE = 8'hC0;
    localparam logic [7:0] CMD_PAGE_BASE  = 8'hB8;
    localparam logic [7:0] CMD_Y_BASE     = 8'h40;

    typedef enum logic [2:0] {
        LCD_RST   = 3'd0,
        INIT_ON   = 3'd1,
        INIT_LINE = 3'd2,
        SET_PAGE  = 3'd3,
        SET_Y     = 3'd4,
        REQ       = 3'd5,
        WAIT_DATA = 3'd6,
        WR_DATA   = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP = 2'd0,
        PH_HIGH  = 2'd1,
        PH_HOLD  = 2'd2
    } bus_phase_t;

    // Page-address command: the page number sits in the low three bits.
    function automatic logic [7:0] page_cmd(input logic [2:0] page);
        return CMD_PAGE_BASE | {5'b00000, page};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_stream_ctrl_bus.sv
`default_nettype none
// ============================================================================
// Module      : lcd_bus_write
// Description : Performs one LCD bus write: setup (E low), E high, hold (E
//               low), each T_PH cycles. DI/DATA are captured on start and
//               held until the next start.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               start, di, wr_byte - request and the value to write
//               busy, done         - write in progress / one-cycle completion
//               lcd_di, lcd_e, lcd_data - LCD bus pins (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_bus_write
    import lcd_stream_ctrl_pkg::*;
#(
    parameter int T_PH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       di,
    input  logic [7:0] wr_byte,
    output logic       busy,
    output logic       done,
    output logic       lcd_di,
    output logic       lcd_e,
    output logic [7:0] lcd_data
);

    bus_phase_t r_phase;
    logic [7:0] r_cnt;
    logic       r_busy;
    logic       r_done;
    logic       r_lcd_di;
    logic       r_lcd_e;
    logic [7:0] r_lcd_data;
    logic       w_last;

    assign w_last = (r_cnt == 8'(T_PH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase    <= PH_SETUP;
            r_cnt      <= 8'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_lcd_di   <= 1'b0;
            r_lcd_e    <= 1'b0;
            r_lcd_data <= 8'h00;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (start) begin
                    r_busy     <= 1'b1;
                    r_phase    <= PH_SETUP;
                    r_cnt      <= 8'd0;
                    r_lcd_di   <= di;
                    r_lcd_data <= wr_byte;
                    r_lcd_e    <= 1'b0;
                end
            end else if (w_last) begin
                r_cnt <= 8'd0;
                case (r_phase)
                    PH_SETUP: begin
                        r_phase <= PH_HIGH;
                        r_lcd_e <= 1'b1;
                    end
                    PH_HIGH: begin
                        r_phase <= PH_HOLD;
                        r_lcd_e <= 1'b0;
                    end
                    default: begin
                        r_phase <= PH_SETUP;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                endcase
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign lcd_di   = r_lcd_di;
    assign lcd_e    = r_lcd_e;
    assign lcd_data = r_lcd_data;

endmodule
`default_nettype wire

// File: rtl/lcd_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lcd_stream_ctrl
// Description : Streams a 64x64 image from a frame-buffer controller into the
//               left half of a KS0108-style LCD. After an LCD reset and init
//               it refreshes forever page by page, requesting one byte per
//               column with a one-cycle en pulse and retrying on timeout.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               data_in, data_valid  - pixel byte and its strobe
//               en                   - byte request pulse
//               lcd_rst, lcd_cs1/2, lcd_di, lcd_rw, lcd_e, lcd_data - LCD
//               frame_done           - pulse after the last byte of a frame
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_stream_ctrl
    import lcd_stream_ctrl_pkg::*;
#(
    parameter int T_PH    = 4,
    parameter int RST_CYC = 16,
    parameter int REQ_TMO = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       en,
    output logic       lcd_rst,
    output logic       lcd_cs1,
    output logic       lcd_cs2,
    output logic       lcd_di,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data,
    output logic       frame_done
);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_page;
    logic [5:0]  r_col;
    logic        r_en;
    logic        r_lcd_rst;
    logic        r_frame_done;
    logic        r_pend;
    logic        r_wr_di;
    logic [7:0]  r_wr_byte;
    logic        w_busy;
    logic        w_done;
    logic        w_start;

    // A write is queued in r_pend and launched once the bus engine is idle.
    assign w_start = r_pend & ~w_busy;

    lcd_bus_write #(
        .T_PH(T_PH)
    ) u_bus (
        .clk     (clk),
        .rst     (rst),
        .start   (w_start),
        .di      (r_wr_di),
        .wr_byte (r_wr_byte),
        .busy    (w_busy),
        .done    (w_done),
        .lcd_di  (lcd_di),
        .lcd_e   (lcd_e),
        .lcd_data(lcd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= LCD_RST;
            r_cnt        <= 16'd0;
            r_page       <= 3'd0;
            r_col        <= 6'd0;
            r_en         <= 1'b0;
            r_lcd_rst    <= 1'b0;
            r_frame_done <= 1'b0;
            r_pend       <= 1'b0;
            r_wr_di      <= 1'b0;
            r_wr_byte    <= 8'h00;
        end else begin
            r_en         <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_start) begin
                r_pend <= 1'b0;
            end
            case (r_state)
                LCD_RST: begin
                    if (r_cnt == 16'(RST_CYC - 1)) begin
                        r_cnt     <= 16'd0;
                        r_lcd_rst <= 1'b1;
                        r_state   <= INIT_ON;
                        r_pend    <= 1'b1;
                        r_wr_di   <= 1'b0;
                        r_wr_byte <= CMD_DISP_ON;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                INIT_ON: begin
                    if (w_done) begin
                        r_state   <= INIT_LINE;
                        r_pend    <= 1'b1;
                        r_wr_byte <= CMD_START_LINE;
                    end
                end
                INIT_LINE: begin
                    if (w_done) begin
                        r_state   <= SET_PAGE;
                        r_page    <= 3'd0;
                        r_pend    <= 1'b1;
                        r_wr_byte <= page_cmd(3'd0);
                    end
                end
                SET_PAGE: begin
                    if (w_done) begin
                        r_state   <= SET_Y;
                        r_pend    <= 1'b1;
                        r_wr_di   <= 1'b0;
                        r_wr_byte <= CMD_Y_BASE;
                    end
                end
                SET_Y: begin
                    if (w_done) begin
                        r_state <= REQ;
                        r_col   <= 6'd0;
                        r_en    <= 1'b1;
                    end
                end
                REQ: begin
                    // en was raised on entry; it drops as we leave.
                    r_state <= WAIT_DATA;
                    r_cnt   <= 16'd0;
                end
                WAIT_DATA: begin
                    if (data_valid) begin
                        r_state   <= WR_DATA;
                        r_pend    <= 1'b1;
                        r_wr_di   <= 1'b1;
                        r_wr_byte <= data_in;
                    end else if (r_cnt == 16'(REQ_TMO - 1)) begin
                        // Producer ignored the request; ask again.
                        r_state <= REQ;
                        r_en    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                WR_DATA: begin
                    if (w_done) begin
                        r_col <= r_col + 6'd1;
                        if (r_col == 6'd63) begin
                            r_page    <= r_page + 3'd1;
                            r_state   <= SET_PAGE;
                            r_pend    <= 1'b1;
                            r_wr_di   <= 1'b0;
                            r_wr_byte <= page_cmd(r_page + 3'd1);
                            if (r_page == 3'd7) begin
                                r_frame_done <= 1'b1;
                            end
                        end else begin
                            r_state <= REQ;
                            r_en    <= 1'b1;
                        end
                    end
                end
                default: r_state <= LCD_RST;
            endcase
        end
    end

    assign en         = r_en;
    assign lcd_rst    = r_lcd_rst;
    assign frame_done = r_frame_done;
    // Only the left half is used, and the bus is write-only.
    assign lcd_cs1    = 1'b1;
    assign lcd_cs2    = 1'b0;
    assign lcd_rw     = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_lcd_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_stream_ctrl
// Description : Self-checking bench for lcd_stream_ctrl. A randomized
//               producer answers or ignores en requests and injects stray
//               data_valid pulses; a monitor rebuilds each LCD bus write and
//               checks it against the expected command/data stream computed
//               from the page/column arithmetic and the bytes delivered.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_stream_ctrl;

    localparam int T_PH    = 4;
    localparam int RST_CYC = 16;
    localparam int REQ_TMO = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       en, lcd_rst, lcd_cs1, lcd_cs2, lcd_di, lcd_rw, lcd_e, frame_done;
    logic [7:0] lcd_data;

    always #5 clk = ~clk;

    lcd_stream_ctrl #(
        .T_PH   (T_PH),
        .RST_CYC(RST_CYC),
        .REQ_TMO(REQ_TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .data_valid(data_valid),
        .en        (en),
        .lcd_rst   (lcd_rst),
        .lcd_cs1   (lcd_cs1),
        .lcd_cs2   (lcd_cs2),
        .lcd_di    (lcd_di),
        .lcd_rw    (lcd_rw),
        .lcd_e     (lcd_e),
        .lcd_data  (lcd_data),
        .frame_done(frame_done)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0] exp_pix[$];   // bytes handed to the DUT, in order
    logic [8:0] cap[$];       // {di, data} of every completed bus write since reset
    int         data_wr = 0;  // data writes seen since reset
    int         frames  = 0;  // frame_done pulses seen since reset
    int         mode    = 0;  // 0 idle, 1 answer all, 2 answer ~3/4

    // ------------------------------------------------------------------
    // Producer: reacts to en one cycle later, holds off after every 64th
    // byte, and throws stray strobes while the LCD strobe is high.
    // ------------------------------------------------------------------
    initial begin : producer
        bit pend;
        int hold;
        int delivered;
        pend = 0; hold = 0; delivered = 0;
        forever begin
            @(posedge clk);
            #1;
            data_valid = 1'b0;
            if (rst) begin
                pend = 0; hold = 0; delivered = 0;
            end else begin
                if (hold > 0) hold--;
                if (pend) begin
                    data_valid = 1'b1;
                    data_in    = (delivered < 64) ? 8'(delivered) : 8'($urandom);
                    exp_pix.push_back(data_in);
                    delivered++;
                    pend = 0;
                    if (delivered % 64 == 0) hold = 10; // delivery cycle + 9 refill cycles
                end else if (lcd_e && $urandom_range(0, 2) == 0) begin
                    data_valid = 1'b1;
                    data_in    = 8'($urandom);
                end
                if (en && hold == 0) begin
                    if (mode == 1) pend = 1;
                    else if (mode == 2 && $urandom_range(0, 3) != 0) pend = 1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Compare process
    // ------------------------------------------------------------------
    int         cyc = 0, last_en = 0, rst_run = 0, stab = 0, hi_len = 0, post = 0;
    bit         have_last = 0, win_dv = 0, prev_en = 0, prev_e = 0, prev_fd = 0, lcd_rel = 0;
    logic [8:0] prev_val = 9'h000, held = 9'h000;

    always @(negedge clk) begin : monitor
        logic [8:0] cur, expv;
        int n, m;
        cur = {lcd_di, lcd_data};
        cyc++;
        if (rst) begin
            exp_pix.delete();
            cap.delete();
            data_wr = 0; frames = 0; have_last = 0; win_dv = 0;
            prev_en = 0; prev_e = 0; prev_fd = 0; lcd_rel = 0;
            rst_run = 0; stab = 0; hi_len = 0; post = 0; prev_val = cur;
        end else begin
            chk("cs1_rw_cs2", {29'd0, lcd_cs1, lcd_cs2, lcd_rw}, 32'h4);

            if (!lcd_rel) begin
                if (!lcd_rst) rst_run++;
                else begin
                    lcd_rel = 1;
                    chk("lcd_rst_low_cycles", rst_run, RST_CYC);
                end
            end else if (!lcd_rst) begin
                chk("lcd_rst_unexpected_low", lcd_rst, 1);
            end

            if (en) begin
                chk("en_adjacent", prev_en, 0);
                chk("en_during_lcd_reset", lcd_rel, 1);
                if (have_last) begin
                    if (!win_dv) chk("en_retry_interval", cyc - last_en, 1 + REQ_TMO);
                    else         chk("en_gap_after_byte", (cyc - last_en) > 1 + REQ_TMO, 1);
                end
                have_last = 1; last_en = cyc; win_dv = 0;
            end else if (have_last && (cyc - last_en) <= REQ_TMO && data_valid) begin
                win_dv = 1;
            end
            prev_en = en;

            if (frame_done) begin
                chk("frame_done_width", prev_fd, 0);
                frames++;
                chk("frame_done_position", data_wr, frames * 512);
            end
            prev_fd = frame_done;

            if (lcd_e && !prev_e) begin
                chk("setup_cycles", (cur == prev_val) && (stab >= T_PH), 1);
                hi_len = 1;
            end else if (lcd_e) begin
                hi_len++;
                chk("data_stable_e_high", cur, prev_val);
            end else if (prev_e) begin
                chk("e_high_cycles", hi_len, T_PH);
                n = cap.size();
                if (n == 0)      expv = 9'h03F;
                else if (n == 1) expv = 9'h0C0;
                else begin
                    m = n - 2;
                    if (m % 66 == 0)      expv = {1'b0, 8'hB8 + 8'((m / 66) % 8)};
                    else if (m % 66 == 1) expv = 9'h040;
                    else if (exp_pix.size() == 0) begin
                        chk("data_underrun", 0, 1);
                        expv = 9'h1FF;
                    end else expv = {1'b1, exp_pix.pop_front()};
                end
                chk("frames_before_write", frames, data_wr / 512);
                chk($sformatf("write_%0d", n), cur, expv);
                cap.push_back(cur);
                if (cur[8]) data_wr++;
                held = cur;
                post = 1;
            end else if (post > 0 && post < T_PH) begin
                chk("data_hold", cur, held);
                post++;
            end
            stab = (cur == prev_val) ? stab + 1 : 1;
            prev_val = cur;
            prev_e = lcd_e;
        end
    end

    task automatic wait_cap(input int n, input int lim, input string what);
        int i;
        i = 0;
        while (cap.size() < n && i < lim) begin
            @(posedge clk);
            i++;
        end
        chk(what, cap.size() >= n, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_en"},       en,         0);
        chk({tag, "_lcd_rst"},  lcd_rst,    0);
        chk({tag, "_cs1"},      lcd_cs1,    1);
        chk({tag, "_cs2"},      lcd_cs2,    0);
        chk({tag, "_di"},       lcd_di,     0);
        chk({tag, "_rw"},       lcd_rw,     0);
        chk({tag, "_e"},        lcd_e,      0);
        chk({tag, "_data"},     lcd_data,   0);
        chk({tag, "_frame"},    frame_done, 0);
    endtask

    task automatic chk_init_writes(input string tag);
        chk({tag, "_w0"}, cap[0], 9'h03F);
        chk({tag, "_w1"}, cap[1], 9'h0C0);
        chk({tag, "_w2"}, cap[2], 9'h0B8);
        chk({tag, "_w3"}, cap[3], 9'h040);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int i;
        rst  = 1'b1;
        mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        #1 rst = 1'b0;

        // Idle producer: init sequence, then en retries every 1+REQ_TMO cycles.
        wait_cap(4, 2000, "init_writes_seen");
        chk_init_writes("init");
        repeat (40) @(posedge clk);
        chk("idle_no_data_writes", data_wr, 0);

        // Prompt producer: first page is 0x00..0x3F, then the next page command.
        #2 mode = 1;
        wait_cap(70, 5000, "page0_seen");
        chk("first_data",      cap[4],  9'h100);
        chk("last_data_page0", cap[67], 9'h13F);
        chk("page1_cmd",       cap[68], 9'h0B9);
        chk("page1_y",         cap[69], 9'h040);

        // Randomly lossy producer across a frame boundary.
        mode = 2;
        wait_cap(532, 30000, "frame1_seen");
        chk("frame_count", frames, 1);
        chk("frame2_page_cmd", cap[530], 9'h0B8);
        chk("frame2_y_cmd",    cap[531], 9'h040);

        // Reset in the middle of a data write on page 3 of the second frame.
        wait_cap(2 + 8 * 66 + 3 * 66 + 10, 20000, "page3_seen");
        i = 0;
        while (!(lcd_e && lcd_di) && i < 200) begin
            @(posedge clk);
            #2;
            i++;
        end
        chk("found_data_write", lcd_e && lcd_di, 1);
        mode = 0;
        rst  = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_outputs("midrst");
        #1 rst = 1'b0;

        wait_cap(4, 2000, "reinit_writes_seen");
        chk_init_writes("reinit");
        repeat (20) @(posedge clk);
        #2 mode = 1;
        wait_cap(10, 2000, "restart_data_seen");
        chk("restart_first_data", cap[4], 9'h100);
        chk("restart_second_data", cap[5], 9'h101);

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
